// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the MixColumns/InvMixColumns engine.
//   - AES_COLS : number of 32-bit columns in a 128-bit AES state
//   - state_e  : engine FSM encoding (IDLE, BUSY, DONE)
//   - xtime()  : multiply a GF(2^8) element by x, modulo x^8+x^4+x^3+x+1
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Shift left by one; when the top bit falls off, fold it back with 0x1b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// -----------------------------------------------------------------------------
// mix_col_unit
//   Combinational transform of one 32-bit AES column. Both the forward
//   (MixColumns) and inverse (InvMixColumns) matrices are evaluated and the
//   result is selected by dec_i. All multiples are built from xtime chains.
// Ports
//   col_i  in  32  column, row 0 in bits [31:24]
//   dec_i  in   1  0 = MixColumns, 1 = InvMixColumns
//   col_o  out 32  transformed column, same row layout
// -----------------------------------------------------------------------------
module mix_col_unit
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        dec_i,
    output logic [31:0] col_o
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    logic [31:0] enc_col;
    logic [31:0] dec_col;

    // Per-row multiples: 3 = 2+1, 9 = 8+1, B = 8+2+1, D = 8+4+1, E = 8+4+2.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r]  = col_i[31 - 8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m3[r] = x2[r] ^ a[r];
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
    end

    // Forward matrix rows are rotations of {2,3,1,1}.
    assign enc_col = {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
                      a[0]  ^ x2[1] ^ m3[2] ^ a[3],
                      a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
                      m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};

    // Inverse matrix rows are rotations of {E,B,D,9}.
    assign dec_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                      m9[0] ^ me[1] ^ mb[2] ^ md[3],
                      md[0] ^ m9[1] ^ me[2] ^ mb[3],
                      mb[0] ^ md[1] ^ m9[2] ^ me[3]};

    assign col_o = dec_i ? dec_col : enc_col;

endmodule

// File: rtl/mix_col_engine.sv
// -----------------------------------------------------------------------------
// mix_col_engine
//   Multi-cycle MixColumns/InvMixColumns over a full 128-bit AES state.
//   COLS_PER_CYCLE columns are transformed per BUSY cycle (1, 2 or 4), so a
//   block spends 4/COLS_PER_CYCLE cycles in BUSY. With BYPASS_LAST=1 a block
//   flagged in_last is passed through unchanged straight to DONE.
// Ports
//   clk        in    1   clock, rising edge
//   rst_n      in    1   asynchronous active-low reset
//   in_valid   in    1   in_state/in_dec/in_last valid
//   in_ready   out   1   engine accepts a block this cycle
//   in_state   in  128   column c = in_state[127-32c -: 32], row 0 in column MSB
//   in_dec     in    1   0 = MixColumns, 1 = InvMixColumns
//   in_last    in    1   final-round flag (pass-through when BYPASS_LAST=1)
//   out_valid  out   1   out_state valid
//   out_ready  in    1   downstream accepts out_state
//   out_state  out 128   result, same layout as in_state
//   busy       out   1   FSM is in BUSY
// Handshake: a transfer occurs on a rising edge where valid && ready are both
//   high. The producer holds valid and its data until that edge; ready may
//   depend combinationally on the other side (in_ready follows out_ready in
//   DONE so a new block can enter on the same edge the result leaves).
// Debug: the FSM state is held in state_q (type state_e) for checkers to bind.
// -----------------------------------------------------------------------------
module mix_col_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit BYPASS_LAST    = 1'b1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_dec,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $fatal(1, "mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter step wraps to 0 when all four columns go in one cycle.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(AES_COLS - COLS_PER_CYCLE);

    state_e       state_q,     state_d;
    logic [1:0]   cnt_q,       cnt_d;
    logic [127:0] src_q,       src_d;
    logic [127:0] res_q,       res_d;
    logic         dec_q,       dec_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q,      busy_d;

    logic         accept;
    logic         take_bypass;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept      = in_valid && in_ready;
    assign take_bypass = BYPASS_LAST && in_last;

    // Slice k of this cycle handles column cnt_q + k.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx[k] = cnt_q + 2'(k);
            col_in[k]  = src_q[32*(3 - int'(col_idx[k])) +: 32];
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
        mix_col_unit u_unit (
            .col_i (col_in[k]),
            .dec_i (dec_q),
            .col_o (col_out[k])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        res_d       = res_q;
        dec_d       = dec_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE, DONE: begin
                // Result consumed: fall back to IDLE unless a new block enters.
                if (state_q == DONE && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    src_d = in_state;
                    dec_d = in_dec;
                    cnt_d = 2'd0;
                    if (take_bypass) begin
                        res_d       = in_state;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b0;
                    end
                end
            end

            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    res_d[32*(3 - int'(col_idx[k])) +: 32] = col_out[k];
                end
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            src_q       <= '0;
            res_q       <= '0;
            dec_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            res_q       <= res_d;
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = res_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mix_col_engine.sv
// -----------------------------------------------------------------------------
// tb_mix_col_engine
//   Four engine instances share clock and reset:
//     0: COLS_PER_CYCLE=1, BYPASS_LAST=1
//     1: COLS_PER_CYCLE=2, BYPASS_LAST=1
//     2: COLS_PER_CYCLE=4, BYPASS_LAST=1
//     3: COLS_PER_CYCLE=1, BYPASS_LAST=0
//   Each instance is exercised in turn; the others stay idle.
//   Inputs are driven 1ns after the rising edge, outputs sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_mix_col_engine;

    localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] BYP_IN = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] ONES   = {4{32'h01010101}};

    typedef struct {
        logic [127:0] state;
        logic         dec;
        logic         last;
        logic [127:0] exp_byp;   // expected when BYPASS_LAST=1
        logic [127:0] exp_mix;   // expected when BYPASS_LAST=0
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid   [4];
    logic         in_ready_w [4];
    logic [127:0] in_state   [4];
    logic         in_dec     [4];
    logic         in_last    [4];
    logic         out_valid_w[4];
    logic         out_ready  [4];
    logic [127:0] out_state_w[4];
    logic         busy_w     [4];

    logic [127:0] exp_q[$];
    int           n_cmp;
    int           n_fail;
    int           cur;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mix_col_engine #(
            .COLS_PER_CYCLE ((g == 1) ? 2 : ((g == 2) ? 4 : 1)),
            .BYPASS_LAST    ((g == 3) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready_w[g]),
            .in_state  (in_state[g]),
            .in_dec    (in_dec[g]),
            .in_last   (in_last[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state_w[g]),
            .busy      (busy_w[g])
        );
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int cpc_of(input int idx);
        return (idx == 1) ? 2 : ((idx == 2) ? 4 : 1);
    endfunction

    function automatic bit bl_of(input int idx);
        return (idx != 3);
    endfunction

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic dec);
        logic [7:0]   base [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (dec) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 32*c - 8*r -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], base[(j - row) & 3]);
                o[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (inst %0d, t=%0t)", name, act, exp, cur, $time);
        end
    endtask

    // ---------------- scoreboard collector ----------------
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid_w[cur] && out_ready[cur]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %h with no block expected (inst %0d)",
                             out_state_w[cur], cur);
                end else begin
                    e = exp_q.pop_front();
                    check("out_state", out_state_w[cur], e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present one block and hold it until accepted; returns 1ns after the
    // accepting edge with in_valid dropped.
    task automatic send(input int idx, input logic [127:0] st, input logic dec,
                        input logic last, input logic [127:0] exp);
        int t;
        t = 0;
        in_state[idx] = st;
        in_dec[idx]   = dec;
        in_last[idx]  = last;
        in_valid[idx] = 1'b1;
        @(negedge clk);
        while (!in_ready_w[idx] && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_w[idx]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 expected 1 within 64 cycles (inst %0d)", idx);
            in_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        exp_q.push_back(exp);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d blocks outstanding expected 0 (inst %0d)",
                     exp_q.size(), cur);
            exp_q.delete();
        end
    endtask

    // Called 1ns after an accepting edge; counts edges until out_valid.
    task automatic measure_latency(input int idx, output int lat);
        lat = 1;
        while (!out_valid_w[idx] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // ---------------- per-instance suite ----------------
    task automatic run_suite(input int idx, input vec_t vecs[5]);
        int           n;
        int           lat;
        int           lows;
        logic [127:0] s;
        logic [127:0] a_exp;
        logic [127:0] b;
        logic [127:0] e;
        logic         d;
        logic         byp;

        cur = idx;
        n   = 4 / cpc_of(idx);

        // Table vectors: result, latency, and in_* changes while BUSY ignored.
        for (int v = 0; v < 5; v++) begin
            byp = vecs[v].last && bl_of(idx);
            e   = bl_of(idx) ? vecs[v].exp_byp : vecs[v].exp_mix;
            send(idx, vecs[v].state, vecs[v].dec, vecs[v].last, e);
            check("busy_after_accept", busy_w[idx], !byp);
            if (!byp) check("in_ready_busy", in_ready_w[idx], 1'b0);
            in_state[idx] = ~vecs[v].state;
            in_dec[idx]   = ~vecs[v].dec;
            in_last[idx]  = ~vecs[v].last;
            measure_latency(idx, lat);
            check("latency", lat, byp ? 1 : n + 1);
            wait_drain();
        end

        // Round trips: enc(x) then dec of that value returns x.
        for (int i = 0; i < 4; i++) begin
            s = rand128();
            send(idx, s, 1'b0, 1'b0, mix_ref(s, 1'b0));
            send(idx, mix_ref(s, 1'b0), 1'b1, 1'b0, s);
        end
        wait_drain();

        // Backpressure: result held stable while out_ready=0.
        out_ready[idx] = 1'b0;
        s     = rand128();
        a_exp = mix_ref(s, 1'b0);
        send(idx, s, 1'b0, 1'b0, a_exp);
        measure_latency(idx, lat);
        check("bp_latency", lat, n + 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_state", out_state_w[idx], a_exp);
            check("bp_hold_valid", out_valid_w[idx], 1'b1);
            check("bp_in_ready", in_ready_w[idx], 1'b0);
        end
        @(posedge clk);
        #1;
        b              = rand128();
        in_state[idx]  = b;
        in_dec[idx]    = 1'b1;
        in_last[idx]   = 1'b0;
        in_valid[idx]  = 1'b1;
        out_ready[idx] = 1'b1;
        @(negedge clk);
        check("bp_same_cycle_ready", in_ready_w[idx], 1'b1);
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        exp_q.push_back(mix_ref(b, 1'b1));
        lows = 0;
        while (!out_valid_w[idx] && lows < 20) begin
            lows++;
            @(posedge clk);
            #1;
        end
        check("bp_valid_low_cycles", lows, n);
        wait_drain();

        // Back-to-back alternating enc/dec; the next block's in_dec is
        // presented while the current one is still BUSY.
        for (int i = 0; i < 100; i++) begin
            s = rand128();
            d = (i % 2 == 1);
            send(idx, s, d, 1'b0, mix_ref(s, d));
        end
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[5];

        n_cmp  = 0;
        n_fail = 0;
        cur    = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_state[i]  = '0;
            in_dec[i]    = 1'b0;
            in_last[i]   = 1'b0;
            out_ready[i] = 1'b1;
        end

        vecs[0] = '{T1_IN,  1'b0, 1'b0, T1_OUT, T1_OUT};
        vecs[1] = '{T1_OUT, 1'b1, 1'b0, T1_IN,  T1_IN};
        vecs[2] = '{BYP_IN, 1'b0, 1'b1, BYP_IN, mix_ref(BYP_IN, 1'b0)};
        vecs[3] = '{ONES,   1'b0, 1'b0, ONES,   ONES};
        vecs[4] = '{{4{32'hc6c6c6c6}}, 1'b1, 1'b0, {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};

        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            cur = i;
            check("rst_out_valid", out_valid_w[i], 1'b0);
            check("rst_out_state", out_state_w[i], '0);
            check("rst_busy", busy_w[i], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            cur = i;
            check("rst_in_ready", in_ready_w[i], 1'b1);
        end

        for (int i = 0; i < 4; i++) run_suite(i, vecs);

        // Reset in the second BUSY cycle drops the block asynchronously.
        cur = 0;
        send(0, rand128(), 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        check("mid_busy", busy_w[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_out_valid", out_valid_w[0], 1'b0);
        check("mid_rst_out_state", out_state_w[0], '0);
        check("mid_rst_busy", busy_w[0], 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, ONES, 1'b0, 1'b0, ONES);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop if something never completes.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule
